// File: rtl/buffered_uart_rx_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encoding and 8N1 frame constants.
package buffered_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/buffered_uart_rx_core.sv
// Serial-to-byte receiver: 2-flop line synchronizer plus an 8N1 sampling FSM with registered pulses.
module uart_rx_core
    import buffered_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 valid_o,
    output logic                 frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 line;

    assign line = sync_q[1];

    // Samples are taken on the cycle the baud counter sits at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!line) begin
                        state_q <= ST_START;
                        cnt_q   <= HALF_BIT;
                        bit_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!line) begin
                        state_q <= ST_DATA;
                        cnt_q   <= FULL_BIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {line, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_BIT;
                        if (bit_q == LAST_BIT) state_q <= ST_STOP;
                        else                   bit_q   <= bit_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (line) begin
                        byte_q  <= shift_q;
                        valid_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        ferr_q  <= 1'b1;
                        state_q <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (line) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign byte_o      = byte_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/buffered_uart_rx.sv
// UART receiver feeding a first-word-fall-through FIFO with overrun and framing-error pulses.
module buffered_uart_rx
    import buffered_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 ren,
    output logic [DATA_BITS-1:0] dout,
    output logic                 available,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_valid;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_in),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .frame_err_o(frame_err)
    );

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]  rd_ptr_q, rd_ptr_d;
    logic                 overrun_q, overrun_d;
    logic                 empty, full, pop, wr_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign pop   = ren && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_en = rx_valid && (!full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = rx_valid && full && !pop;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_byte;
    end

    assign dout      = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign available = !empty;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_buffered_uart_rx.sv
// Scoreboard bench for buffered_uart_rx at 16 clocks/bit with a 4-entry FIFO.
module tb_buffered_uart_rx;

    localparam int CPB = 16;
    localparam int DL2 = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       ren = 1'b0;
    logic [7:0] dout;
    logic       available, overrun, frame_err;

    int n_chk = 0;
    int n_pass = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    buffered_uart_rx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .ren      (ren),
        .dout     (dout),
        .available(available),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles, so a clean one-cycle pulse adds exactly one.
    always @(posedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data);
        exp_q.push_back(data);
        send_frame(data, 1'b1);
    endtask

    task automatic pop_chk(input string tag);
        int waited = 0;
        while (!available && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!available) begin
            chk({tag, "_timeout"}, 32'(available), 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
        end else begin
            chk(tag, 32'(dout), 32'(exp_q.pop_front()));
        end
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    initial begin
        int fe0, ov0;
        logic [7:0] partial;

        repeat (3) @(negedge clk);
        chk("rst_avail", 32'(available), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Two bytes; check push timing relative to the stop-bit sample.
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                chk("avail_before_push", 32'(available), 32'd0);
                @(negedge clk);
                chk("avail_after_push", 32'(available), 32'd1);
                chk("dout_fwft", 32'(dout), 32'hA5);
            end
        join
        send_byte(8'h3C);
        pop_chk("pop_a5");
        pop_chk("pop_3c");
        chk("empty_after_pops", 32'(available), 32'd0);

        // Short glitch must be rejected.
        fe0 = fe_cnt;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_avail", 32'(available), 32'd0);
        chk("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

        // Bad stop bit with the line held low afterwards.
        fe0 = fe_cnt;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = 1'(8'h55 >> i);
            repeat (CPB) @(negedge clk);
        end
        rx_in = 1'b0;
        repeat (CPB + 40) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
        chk("ferr_fifo_empty", 32'(available), 32'd0);
        send_byte(8'h81);
        pop_chk("pop_81");

        // Overrun: fifth byte dropped.
        ov0 = ov_cnt;
        for (int b = 1; b <= 4; b++) send_byte(8'(b));
        send_frame(8'h05, 1'b1);
        chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        for (int b = 1; b <= 4; b++) pop_chk("pop_ovr_seq");
        chk("ovr_drained", 32'(available), 32'd0);

        // Full FIFO with a pop on the exact push edge.
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b));
        ov0 = ov_cnt;
        exp_q.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                chk("simul_pop_head", 32'(dout), 32'(exp_q.pop_front()));
                ren = 1'b1;
                @(negedge clk);
                ren = 1'b0;
            end
        join
        chk("simul_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        for (int b = 0; b < 4; b++) pop_chk("pop_full_seq");
        chk("simul_drained", 32'(available), 32'd0);

        // Reset during data bit 4 with a byte already buffered.
        send_byte(8'h42);
        partial = 8'hA3;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx_in = partial[i];
            repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_avail", 32'(available), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_ferr", 32'(frame_err), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        exp_q.delete();
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h7E);
        pop_chk("pop_7e");
        chk("final_empty", 32'(available), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
